sc_ifu: RTL and testbench

SC_IFU -- requirements
Module: sc_ifu

---
 rtl/sc_ifu.sv | 128 ++++++++++++
 tb/tb_sc_ifu.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/sc_ifu.sv
// Single-cycle core instruction fetch unit: fetches one word, holds it until retired, selects next PC.
// Optional feature: define IFU_ALIGN_CHECK_EN to trap misaligned next-PC targets in a sticky FAULT state.
module sc_ifu #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clock,
    input  logic        resetn,
    input  logic [1:0]  pcsource,
    input  logic [31:0] bpc,
    input  logic [31:0] ra,
    input  logic [31:0] jpc,
    input  logic        inst_done,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic [31:0] inst,
    output logic        inst_valid,
    output logic [31:0] pc,
    output logic [31:0] pc4,
    output logic [31:0] inst_count,
    output logic        misalign,
    output logic [1:0]  dbg_state
);

    // Handshakes: imem_req is held high for the whole FETCH state; the word is taken on the
    // first cycle imem_ack=1 in FETCH. inst_valid stays high in HOLD until inst_done=1 retires it.
`ifdef IFU_ALIGN_CHECK_EN
    typedef enum logic [1:0] {FETCH = 2'd0, HOLD = 2'd1, FAULT = 2'd2} state_t;
`else
    typedef enum logic [1:0] {FETCH = 2'd0, HOLD = 2'd1} state_t;
`endif

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] inst_q, inst_d;
    logic [31:0] count_q, count_d;
    logic [31:0] next_pc;
`ifdef IFU_ALIGN_CHECK_EN
    logic        misalign_q, misalign_d;
`endif

    always_comb begin
        next_pc = pc_q + 32'd4;
        case (pcsource)
            2'b01:   next_pc = bpc;
            2'b10:   next_pc = ra;
            2'b11:   next_pc = jpc;
            default: next_pc = pc_q + 32'd4;
        endcase
    end

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        inst_d  = inst_q;
        count_d = count_q;
`ifdef IFU_ALIGN_CHECK_EN
        misalign_d = misalign_q;
`endif
        case (state_q)
            FETCH: begin
                if (imem_ack) begin
                    inst_d  = imem_rdata;
                    state_d = HOLD;
                end
            end
            HOLD: begin
                if (inst_done) begin
`ifdef IFU_ALIGN_CHECK_EN
                    if (next_pc[1:0] != 2'b00) begin
                        // Faulting target is not retired: pc and count keep the offending instruction.
                        misalign_d = 1'b1;
                        state_d    = FAULT;
                    end else begin
                        pc_d    = next_pc;
                        count_d = count_q + 32'd1;
                        state_d = FETCH;
                    end
`else
                    pc_d    = next_pc & ~32'h3;
                    count_d = count_q + 32'd1;
                    state_d = FETCH;
`endif
                end
            end
            default: state_d = state_q;
        endcase
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state_q <= FETCH;
            pc_q    <= RESET_PC;
            inst_q  <= 32'h0;
            count_q <= 32'h0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            inst_q  <= inst_d;
            count_q <= count_d;
        end
    end

`ifdef IFU_ALIGN_CHECK_EN
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            misalign_q <= 1'b0;
        end else begin
            misalign_q <= misalign_d;
        end
    end
    assign misalign = misalign_q;
`else
    assign misalign = 1'b0;
`endif

    // Gate with resetn so no request escapes while reset is held.
    assign imem_req   = resetn && (state_q == FETCH);
    assign imem_addr  = pc_q;
    assign inst_valid = (state_q == HOLD);
    assign inst       = inst_q;
    assign pc         = pc_q;
    assign pc4        = pc_q + 32'd4;
    assign inst_count = count_q;
    assign dbg_state  = state_q;

endmodule

// File: tb/tb_sc_ifu.sv
// Self-checking bench for sc_ifu: vector table of fetch/retire steps plus reset and alignment sequences.
module tb_sc_ifu;

    logic        clock;
    logic        resetn;
    logic [1:0]  pcsource;
    logic [31:0] bpc, ra, jpc;
    logic        inst_done;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic [31:0] inst;
    logic        inst_valid;
    logic [31:0] pc, pc4, inst_count;
    logic        misalign;
    logic [1:0]  dbg_state;

    sc_ifu #(.RESET_PC(32'h0000_0000)) dut (
        .clock(clock), .resetn(resetn), .pcsource(pcsource), .bpc(bpc), .ra(ra), .jpc(jpc),
        .inst_done(inst_done), .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack),
        .imem_rdata(imem_rdata), .inst(inst), .inst_valid(inst_valid), .pc(pc), .pc4(pc4),
        .inst_count(inst_count), .misalign(misalign), .dbg_state(dbg_state)
    );

    // clock / reset
    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct {
        logic [31:0] exp_addr;
        logic [31:0] rdata;
        int          dly;
        logic [1:0]  sel;
        logic [31:0] tgt;
        logic [31:0] exp_next;
        int          n_done;
    } vec_t;

    vec_t        vecs[7];
    logic [31:0] exp_q[$];
    logic [31:0] exp_count;
    int          n_checks;
    int          n_fail;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // driver: wait for a request, check it, ack after dly cycles, then check the held word
    task automatic fetch_one(input logic [31:0] exp_addr, input logic [31:0] rdata, input int dly);
        int waited;
        logic [31:0] exp_inst;
        waited = 0;
        while (!imem_req && waited < 20) begin
            @(negedge clock);
            waited++;
        end
        check("req_seen", {31'b0, imem_req}, 32'd1);
        check("imem_addr", imem_addr, exp_addr);
        check("pc4", pc4, exp_addr + 32'd4);
        check("valid_in_fetch", {31'b0, inst_valid}, 32'd0);
        for (int i = 0; i < dly; i++) begin
            inst_done = 1'b1;  // must be ignored while fetching
            @(negedge clock);
            check("req_held", {31'b0, imem_req}, 32'd1);
        end
        inst_done  = 1'b0;
        imem_ack   = 1'b1;
        imem_rdata = rdata;
        exp_q.push_back(rdata);
        @(negedge clock);
        imem_ack = 1'b0;
        check("inst_valid", {31'b0, inst_valid}, 32'd1);
        check("req_in_hold", {31'b0, imem_req}, 32'd0);
        check("pc_in_hold", pc, exp_addr);
        check("count_in_hold", inst_count, exp_count);
        if (inst_valid && exp_q.size() > 0) begin
            exp_inst = exp_q.pop_front();
            check("inst", inst, exp_inst);
        end
        // stray ack in HOLD must not disturb the held word
        imem_ack   = 1'b1;
        imem_rdata = 32'hDEAD_BEEF;
        @(negedge clock);
        imem_ack = 1'b0;
        check("inst_stray_ack", inst, rdata);
        check("valid_stray_ack", {31'b0, inst_valid}, 32'd1);
    endtask

    task automatic retire(input logic [1:0] sel, input logic [31:0] tgt, input int n_done);
        pcsource = sel;
        bpc = $urandom();
        ra  = $urandom();
        jpc = $urandom();
        case (sel)
            2'b01:   bpc = tgt;
            2'b10:   ra  = tgt;
            2'b11:   jpc = tgt;
            default: ;
        endcase
        inst_done = 1'b1;
        for (int i = 0; i < n_done; i++) @(negedge clock);
        inst_done = 1'b0;
    endtask

    initial begin
        n_checks  = 0;
        n_fail    = 0;
        exp_count = 0;
        resetn    = 1'b0;
        pcsource  = 2'b00;
        bpc = 0; ra = 0; jpc = 0;
        inst_done  = 1'b0;
        imem_ack   = 1'b0;
        imem_rdata = 32'h0;

        //          exp_addr        rdata          dly sel    tgt             exp_next      n_done
        vecs[0] = '{32'h0000_0000, 32'h2001_0005, 3, 2'b00, 32'h0,          32'h0000_0004, 1};
        vecs[1] = '{32'h0000_0004, 32'h1111_2222, 0, 2'b01, 32'h0000_0040, 32'h0000_0040, 5};
        vecs[2] = '{32'h0000_0040, 32'h3333_4444, 1, 2'b10, 32'h0000_0100, 32'h0000_0100, 1};
        vecs[3] = '{32'h0000_0100, 32'h5555_6666, 2, 2'b11, 32'h0400_0000, 32'h0400_0000, 3};
        vecs[4] = '{32'h0400_0000, 32'h7777_8888, 0, 2'b11, 32'hFFFF_FFFC, 32'hFFFF_FFFC, 1};
        vecs[5] = '{32'hFFFF_FFFC, 32'h9999_AAAA, 1, 2'b00, 32'h0,          32'h0000_0000, 2};
        vecs[6] = '{32'h0000_0000, 32'hBBBB_CCCC, 0, 2'b10, 32'h0000_0008, 32'h0000_0008, 1};

        // reset state
        #3;
        check("rst_req", {31'b0, imem_req}, 32'd0);
        check("rst_valid", {31'b0, inst_valid}, 32'd0);
        check("rst_pc", pc, 32'h0);
        check("rst_pc4", pc4, 32'h4);
        check("rst_count", inst_count, 32'h0);
        check("rst_misalign", {31'b0, misalign}, 32'd0);
        check("rst_inst", inst, 32'h0);
        repeat (2) @(negedge clock);
        resetn = 1'b1;
        #1;
        check("first_req", {31'b0, imem_req}, 32'd1);

        for (int i = 0; i < 7; i++) begin
            fetch_one(vecs[i].exp_addr, vecs[i].rdata, vecs[i].dly);
            retire(vecs[i].sel, vecs[i].tgt, vecs[i].n_done);
            exp_count++;
            check("next_pc", pc, vecs[i].exp_next);
            check("count", inst_count, exp_count);
            check("req_after_done", {31'b0, imem_req}, 32'd1);
        end

        // reset during an outstanding fetch; a stray ack during reset is dropped
        @(negedge clock);
        resetn   = 1'b0;
        imem_ack = 1'b1;
        #1;
        check("mid_rst_pc", pc, 32'h0);
        check("mid_rst_valid", {31'b0, inst_valid}, 32'd0);
        check("mid_rst_req", {31'b0, imem_req}, 32'd0);
        check("mid_rst_count", inst_count, 32'h0);
        @(negedge clock);
        imem_ack = 1'b0;
        @(negedge clock);
        resetn    = 1'b1;
        exp_count = 0;
        #1;
        check("post_rst_req", {31'b0, imem_req}, 32'd1);
        check("post_rst_addr", imem_addr, 32'h0);
        check("post_rst_valid", {31'b0, inst_valid}, 32'd0);

        // misaligned jr target
        fetch_one(32'h0, 32'h0000_0008, 1);
        retire(2'b10, 32'h0000_0102, 1);
`ifdef IFU_ALIGN_CHECK_EN
        check("mis_flag", {31'b0, misalign}, 32'd1);
        check("mis_pc", pc, 32'h0);
        check("mis_count", inst_count, 32'h0);
        check("mis_state", {30'b0, dbg_state}, 32'd2);
        for (int i = 0; i < 3; i++) begin
            imem_ack  = 1'b1;
            inst_done = 1'b1;
            @(negedge clock);
            check("fault_req", {31'b0, imem_req}, 32'd0);
            check("fault_valid", {31'b0, inst_valid}, 32'd0);
            check("fault_sticky", {31'b0, misalign}, 32'd1);
        end
        imem_ack  = 1'b0;
        inst_done = 1'b0;
`else
        exp_count++;
        check("align_pc", pc, 32'h0000_0100);
        check("align_count", inst_count, exp_count);
        check("align_misalign", {31'b0, misalign}, 32'd0);
        check("align_req", {31'b0, imem_req}, 32'd1);
`endif
        check("sb_empty", exp_q.size(), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

endmodule
